// File: rtl/prison_game_ctrl_pkg.sv
// Shared constants, widths and state encoding for the prison game controller.
package prison_pkg;

   localparam int N_PRISONERS = 100;
   localparam int MAX_OPENS   = 50;

   localparam int IDX_W  = 7;   // prisoner / box index width
   localparam int CNT_W  = 6;   // per-prisoner open counter width
   localparam int OPEN_W = 13;  // run-wide open counter width

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [OPEN_W-1:0] sat_inc_opens(input logic [OPEN_W-1:0] v);
      logic [OPEN_W-1:0] r;
      if (v == {OPEN_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(OPEN_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/prison_game_ctrl.sv
// Loop-following controller for the 100-prisoners game: each prisoner starts at
// his own box and follows box contents until he finds his number or runs out
// of opens. Reads go to an external box array with arbitrary latency.
module prison_game_ctrl
   import prison_pkg::*;
#(
   parameter int          N_PRISONERS = prison_pkg::N_PRISONERS,
   parameter int          MAX_OPENS   = prison_pkg::MAX_OPENS,
   parameter logic [31:0] GUARD_KEY   = 32'hC0DE_0100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       guard_key,
   output logic              box_rd_en,
   output logic [IDX_W-1:0]  box_rd_addr,
   input  logic              box_rd_valid,
   input  logic [IDX_W-1:0]  box_rd_data,
   output logic              busy,
   output logic              done,
   output logic              win,
   output logic [IDX_W-1:0]  fail_id,
   output logic [OPEN_W-1:0] total_opens,
   output logic              key_err,
   output logic              bad_content
);

   state_t             state_r, state_nxt;
   logic [IDX_W-1:0]   p_r, p_nxt;          // current prisoner
   logic [CNT_W-1:0]   c_r, c_nxt;          // opens used by current prisoner
   logic [IDX_W-1:0]   addr_r, addr_nxt;    // next box to open
   logic [IDX_W-1:0]   data_r, data_nxt;    // content of last opened box
   logic [OPEN_W-1:0]  opens_nxt;
   logic               win_nxt, bad_nxt, key_err_nxt;
   logic [IDX_W-1:0]   fail_nxt;
   logic               key_ok_s;

   assign key_ok_s = (guard_key == GUARD_KEY);

   // Next-state and next-datapath decode; abort overrides everything.
   always_comb begin
      state_nxt   = state_r;
      p_nxt       = p_r;
      c_nxt       = c_r;
      addr_nxt    = addr_r;
      data_nxt    = data_r;
      opens_nxt   = total_opens;
      win_nxt     = win;
      fail_nxt    = fail_id;
      bad_nxt     = bad_content;
      key_err_nxt = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start && key_ok_s) begin
                  state_nxt = ISSUE;
                  p_nxt     = {IDX_W{1'b0}};
                  c_nxt     = CNT_W'(1);
                  addr_nxt  = {IDX_W{1'b0}};
                  opens_nxt = {OPEN_W{1'b0}};
                  win_nxt   = 1'b0;
                  fail_nxt  = {IDX_W{1'b0}};
                  bad_nxt   = 1'b0;
               end else if (start) begin
                  key_err_nxt = 1'b1;
               end else begin
                  state_nxt = state_r;
               end
            end
            ISSUE: begin
               opens_nxt = sat_inc_opens(total_opens);
               state_nxt = WAIT;
            end
            WAIT: begin
               if (box_rd_valid) begin
                  data_nxt  = box_rd_data;
                  state_nxt = CHECK;
               end else begin
                  state_nxt = WAIT;
               end
            end
            CHECK: begin
               if (data_r >= IDX_W'(N_PRISONERS)) begin
                  bad_nxt   = 1'b1;
                  win_nxt   = 1'b0;
                  fail_nxt  = p_r;
                  state_nxt = DONE;
               end else if (data_r == p_r) begin
                  if (p_r == IDX_W'(N_PRISONERS - 1)) begin
                     win_nxt   = 1'b1;
                     state_nxt = DONE;
                  end else begin
                     p_nxt     = p_r + IDX_W'(1);
                     c_nxt     = CNT_W'(1);
                     addr_nxt  = p_r + IDX_W'(1);
                     state_nxt = ISSUE;
                  end
               end else if (c_r == CNT_W'(MAX_OPENS)) begin
                  win_nxt   = 1'b0;
                  fail_nxt  = p_r;
                  state_nxt = DONE;
               end else begin
                  addr_nxt  = data_r;
                  c_nxt     = c_r + CNT_W'(1);
                  state_nxt = ISSUE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered outputs; outputs derive from next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         p_r         <= {IDX_W{1'b0}};
         c_r         <= {CNT_W{1'b0}};
         addr_r      <= {IDX_W{1'b0}};
         data_r      <= {IDX_W{1'b0}};
         box_rd_en   <= 1'b0;
         box_rd_addr <= {IDX_W{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         win         <= 1'b0;
         fail_id     <= {IDX_W{1'b0}};
         total_opens <= {OPEN_W{1'b0}};
         key_err     <= 1'b0;
         bad_content <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         p_r         <= p_nxt;
         c_r         <= c_nxt;
         addr_r      <= addr_nxt;
         data_r      <= data_nxt;
         box_rd_en   <= (state_nxt == ISSUE);
         box_rd_addr <= (state_nxt == ISSUE) ? addr_nxt : {IDX_W{1'b0}};
         busy        <= (state_nxt == ISSUE) || (state_nxt == WAIT) || (state_nxt == CHECK);
         done        <= (state_nxt == DONE);
         win         <= win_nxt;
         fail_id     <= fail_nxt;
         total_opens <= opens_nxt;
         key_err     <= key_err_nxt;
         bad_content <= bad_nxt;
      end
   end

endmodule

// File: tb/tb_prison_game_ctrl.sv
// Self-checking bench: table of permutation scenarios checked against constants
// and a loop-following reference model, plus key-error, abort and reset sequences.
module tb_prison_game_ctrl;

   localparam int          N    = 100;
   localparam int          MAXO = 50;
   localparam logic [31:0] KEY  = 32'hC0DE_0100;

   logic        clk, rst, start, abort;
   logic [31:0] guard_key;
   logic        box_rd_en, box_rd_valid;
   logic [6:0]  box_rd_addr, box_rd_data, fail_id;
   logic        busy, done, win, key_err, bad_content;
   logic [12:0] total_opens;

   logic        resp_valid, spur_valid;
   logic [6:0]  resp_data;
   int          resp_addr, resp_lat;
   int          perm [0:N-1];
   int          rd_count;
   logic        prev_en;
   int          checks, failures;

   assign box_rd_valid = resp_valid | spur_valid;
   assign box_rd_data  = resp_data;

   prison_game_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .guard_key(guard_key),
      .box_rd_en(box_rd_en), .box_rd_addr(box_rd_addr),
      .box_rd_valid(box_rd_valid), .box_rd_data(box_rd_data),
      .busy(busy), .done(done), .win(win), .fail_id(fail_id),
      .total_opens(total_opens), .key_err(key_err), .bad_content(bad_content)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Box array responder: answers each read strobe after 1-2 cycles.
   always begin
      @(negedge clk);
      if (box_rd_en === 1'b1) begin
         resp_addr = int'(box_rd_addr);
         resp_lat  = int'($urandom_range(1, 2));
         repeat (resp_lat) @(negedge clk);
         resp_data  = (resp_addr < N) ? 7'(perm[resp_addr]) : 7'd0;
         resp_valid = 1'b1;
         @(negedge clk);
         resp_valid = 1'b0;
      end
   end

   // Read monitor: counts strobes and flags back-to-back strobes.
   always @(negedge clk) begin
      if (box_rd_en === 1'b1) begin
         rd_count++;
         chk("rd_en_single_cycle", int'(prev_en), 0);
      end
      prev_en <= box_rd_en;
   end

   // Reference: each prisoner follows the chain from his own box.
   function automatic void model(output int w, output int f, output int o, output int b);
      int box, d;
      bit found;
      w = 1; f = 0; o = 0; b = 0;
      for (int p = 0; p < N; p++) begin
         box = p;
         found = 1'b0;
         for (int k = 0; k < MAXO; k++) begin
            o++;
            d = perm[box];
            if (d >= N) begin
               b = 1; w = 0; f = p;
               return;
            end
            if (d == p) begin
               found = 1'b1;
               break;
            end
            box = d;
         end
         if (!found) begin
            w = 0; f = p;
            return;
         end
      end
   endfunction

   task automatic fill(input int kind);
      int j, t;
      for (int i = 0; i < N; i++) begin
         case (kind)
            1:       perm[i] = (i + 1) % N;
            2:       perm[i] = (i + 1) % 50 + 50 * (i / 50);
            default: perm[i] = i;
         endcase
      end
      if (kind == 3) perm[0] = 120;
      if (kind == 4) begin
         for (int i = N - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
         end
      end
   endtask

   task automatic start_run();
      @(negedge clk);
      rd_count  = 0;
      start     = 1'b1;
      guard_key = KEY;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk({name, "_timeout"}, 0, 1);
         @(negedge clk); abort = 1'b1;
         @(negedge clk); abort = 1'b0;
      end
   endtask

   typedef struct {
      string name;
      int    kind;
      int    exp_win;
      int    exp_fail;
      int    exp_opens;
      int    exp_bad;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int  mw, mf, mo, mb, ew, ef, eo, eb, rc;
      bit  ok;
      checks = 0; failures = 0; rd_count = 0; prev_en = 1'b0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; guard_key = 32'd0;
      resp_valid = 1'b0; spur_valid = 1'b0; resp_data = 7'd0;
      fill(0);

      vecs[0] = '{"identity",   0, 1, 0, 100,  0};
      vecs[1] = '{"one_cycle",  1, 0, 0, 50,   0};
      vecs[2] = '{"two_cycles", 2, 1, 0, 5000, 0};
      vecs[3] = '{"bad_box0",   3, 0, 0, 1,    1};
      vecs[4] = '{"random_a",   4, -1, -1, -1, -1};
      vecs[5] = '{"random_b",   4, -1, -1, -1, -1};
      vecs[6] = '{"restart_id", 0, 1, 0, 100,  0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(box_rd_en), 0);
      chk("rst_opens", int'(total_opens), 0);
      chk("rst_key_err", int'(key_err), 0);
      rst = 1'b1;
      @(negedge clk);

      // Wrong key
      rd_count = 0;
      start = 1'b1; guard_key = 32'd0;
      @(negedge clk);
      start = 1'b0;
      chk("key_err_pulse", int'(key_err), 1);
      chk("key_err_busy", int'(busy), 0);
      @(negedge clk);
      chk("key_err_once", int'(key_err), 0);
      repeat (3) @(negedge clk);
      chk("key_err_busy_after", int'(busy), 0);
      chk("key_err_no_read", rd_count, 0);

      // Stray valid while idle is ignored
      spur_valid = 1'b1;
      repeat (3) @(negedge clk);
      spur_valid = 1'b0;
      @(negedge clk);
      chk("stray_valid_busy", int'(busy), 0);
      chk("stray_valid_done", int'(done), 0);

      // Table of full runs
      foreach (vecs[i]) begin
         fill(vecs[i].kind);
         model(mw, mf, mo, mb);
         ew = (vecs[i].exp_win   >= 0) ? vecs[i].exp_win   : mw;
         ef = (vecs[i].exp_fail  >= 0) ? vecs[i].exp_fail  : mf;
         eo = (vecs[i].exp_opens >= 0) ? vecs[i].exp_opens : mo;
         eb = (vecs[i].exp_bad   >= 0) ? vecs[i].exp_bad   : mb;
         start_run();
         chk({vecs[i].name, "_busy"}, int'(busy), 1);
         wait_done(vecs[i].name, ok);
         if (ok) begin
            chk({vecs[i].name, "_win"}, int'(win), ew);
            if (ew == 0) chk({vecs[i].name, "_fail_id"}, int'(fail_id), ef);
            chk({vecs[i].name, "_opens"}, int'(total_opens), eo);
            chk({vecs[i].name, "_bad"}, int'(bad_content), eb);
            chk({vecs[i].name, "_reads"}, rd_count, eo);
            chk({vecs[i].name, "_busy_done"}, int'(busy), 0);
            repeat (3) @(negedge clk);
            chk({vecs[i].name, "_hold"}, int'(done), 1);
            chk({vecs[i].name, "_hold_opens"}, int'(total_opens), eo);
         end
      end

      // Abort at cycle 20 of a run
      fill(1);
      start_run();
      repeat (18) @(negedge clk);
      start = 1'b1; guard_key = KEY; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_rd_en", int'(box_rd_en), 0);
      rc = rd_count;
      repeat (8) @(negedge clk);
      chk("abort_stays_idle", int'(busy), 0);
      chk("abort_no_reads", rd_count, rc);

      // Reset while waiting for a read
      fill(0);
      start_run();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("wait_rst_busy", int'(busy), 0);
      chk("wait_rst_rd_en", int'(box_rd_en), 0);
      chk("wait_rst_opens", int'(total_opens), 0);
      chk("wait_rst_win", int'(win), 0);
      chk("wait_rst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_idle", int'(busy), 0);
      start_run();
      wait_done("post_rst", ok);
      if (ok) begin
         chk("post_rst_win", int'(win), 1);
         chk("post_rst_opens", int'(total_opens), 100);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
